// File: rtl/dmem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dmem_ctrl
// Brief    : Memory-stage data-memory controller. Bridges the pipeline M stage
//            to a single-port data RAM over a req/ack handshake: byte enables,
//            lane-replicated store data, sub-word load extraction/extension,
//            pipeline stall, misalignment flag and bus-timeout abort.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_ctrl #(
    parameter int          ADDR_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              memreadM,
    input  logic              memwriteM,
    input  logic [1:0]        sizeM,
    input  logic              signedM,
    input  logic [ADDR_W-1:0] aluoutM,
    input  logic [31:0]       writedataM,
    output logic [31:0]       readdataM,
    output logic              stallM,
    output logic              misalignM,
    output logic              buserrM,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata
);

    // Counter only needs to reach TIMEOUT; a disabled timeout keeps a 1-bit stub.
    localparam int              CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);
    localparam logic             TO_EN  = (TIMEOUT != 0);

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic [1:0]       size_q;
    logic             signed_q;
    logic [1:0]       lane_q;
    logic             load_q;

    logic             acc;
    logic             bad;
    logic             start;
    logic [3:0]       be_next;
    logic [31:0]      wdata_next;
    logic [7:0]       byte_sel;
    logic [15:0]      half_sel;
    logic [31:0]      load_ext;

    // Access classification: illegal size or an address not aligned to the size is rejected.
    always_comb begin
        acc       = memreadM | memwriteM;
        bad       = (sizeM == 2'b11)
                  | ((sizeM == SZ_HALF) & aluoutM[0])
                  | ((sizeM == SZ_WORD) & (aluoutM[1:0] != 2'b00));
        start     = acc & ~bad;
        misalignM = acc & bad;
        cnt_inc   = cnt + 1'b1;
    end

    // Stall covers the accepting IDLE cycle and every REQ cycle; forced low while in reset.
    always_comb begin
        stallM = rst & (((state == IDLE) & start) | (state == REQ));
    end

    // Byte enables and lane-replicated store data for the incoming access.
    always_comb begin
        be_next    = 4'b1111;
        wdata_next = writedataM;
        case (sizeM)
            SZ_BYTE: begin
                be_next    = 4'b0001 << aluoutM[1:0];
                wdata_next = {4{writedataM[7:0]}};
            end
            SZ_HALF: begin
                be_next    = aluoutM[1] ? 4'b1100 : 4'b0011;
                wdata_next = {2{writedataM[15:0]}};
            end
            default: begin
                be_next    = 4'b1111;
                wdata_next = writedataM;
            end
        endcase
    end

    // Load lane selection and sign/zero extension using the latched access attributes.
    always_comb begin
        case (lane_q)
            2'd0:    byte_sel = mem_rdata[7:0];
            2'd1:    byte_sel = mem_rdata[15:8];
            2'd2:    byte_sel = mem_rdata[23:16];
            default: byte_sel = mem_rdata[31:24];
        endcase
        half_sel = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (size_q)
            SZ_BYTE: load_ext = {{24{signed_q & byte_sel[7]}}, byte_sel};
            SZ_HALF: load_ext = {{16{signed_q & half_sel[15]}}, half_sel};
            default: load_ext = mem_rdata;
        endcase
    end

    // Access sequencer: latch the request, wait for ack or timeout, present result for one cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            size_q    <= 2'b00;
            signed_q  <= 1'b0;
            lane_q    <= 2'b00;
            load_q    <= 1'b0;
            readdataM <= 32'h0;
            buserrM   <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= 4'b0000;
            mem_wdata <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    buserrM <= 1'b0;
                    if (start) begin
                        mem_req   <= 1'b1;
                        mem_we    <= memwriteM;
                        mem_addr  <= {aluoutM[ADDR_W-1:2], 2'b00};
                        mem_be    <= be_next;
                        mem_wdata <= wdata_next;
                        size_q    <= sizeM;
                        signed_q  <= signedM;
                        lane_q    <= aluoutM[1:0];
                        // A simultaneous read+write is handled as a write.
                        load_q    <= ~memwriteM;
                        cnt       <= '0;
                        state     <= REQ;
                    end else begin
                        readdataM <= 32'h0;
                    end
                end
                REQ: begin
                    if (mem_ack) begin
                        mem_req   <= 1'b0;
                        readdataM <= load_q ? load_ext : 32'h0;
                        state     <= DONE;
                    end else if (TO_EN && (cnt_inc == TO_VAL)) begin
                        mem_req   <= 1'b0;
                        buserrM   <= 1'b1;
                        readdataM <= 32'h0;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                DONE: begin
                    buserrM <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    mem_req <= 1'b0;
                    buserrM <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_ctrl
// Brief    : Self-checking bench for dmem_ctrl with a behavioural access model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_ctrl;

    logic        clk;
    logic        rst;
    logic        memreadM;
    logic        memwriteM;
    logic [1:0]  sizeM;
    logic        signedM;
    logic [31:0] aluoutM;
    logic [31:0] writedataM;
    logic [31:0] readdataM;
    logic        stallM;
    logic        misalignM;
    logic        buserrM;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int checks;
    int errors;

    dmem_ctrl #(
        .ADDR_W  (32),
        .TIMEOUT (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .memreadM   (memreadM),
        .memwriteM  (memwriteM),
        .sizeM      (sizeM),
        .signedM    (signedM),
        .aluoutM    (aluoutM),
        .writedataM (writedataM),
        .readdataM  (readdataM),
        .stallM     (stallM),
        .misalignM  (misalignM),
        .buserrM    (buserrM),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model (plain arithmetic) ----------------
    function automatic logic model_bad(input logic [1:0] sz, input logic [31:0] a);
        int unsigned align;
        align = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        return (sz == 2'd3) || ((a % align) != 0);
    endfunction

    function automatic logic [3:0] model_be(input logic [1:0] sz, input logic [31:0] a);
        int unsigned lane;
        lane = a % 4;
        if (sz == 2'd0) return 4'(1 << lane);
        if (sz == 2'd1) return (lane >= 2) ? 4'd12 : 4'd3;
        return 4'd15;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [1:0] sz, input logic [31:0] wd);
        if (sz == 2'd0) return (wd % 256) * 32'h0101_0101;
        if (sz == 2'd1) return (wd % 65536) * 32'h0001_0001;
        return wd;
    endfunction

    function automatic logic [31:0] model_load(input logic [1:0] sz, input logic sg,
                                               input logic [31:0] a, input logic [31:0] rd);
        logic [31:0] v;
        int unsigned lane;
        lane = a % 4;
        if (sz == 2'd0) begin
            v = (rd / (32'd1 << (8 * lane))) % 256;
            if (sg && v >= 128) v = v + 32'hFFFF_FF00;
        end else if (sz == 2'd1) begin
            v = (rd / (32'd1 << (16 * (lane / 2)))) % 65536;
            if (sg && v >= 32768) v = v + 32'hFFFF_0000;
        end else begin
            v = rd;
        end
        return v;
    endfunction

    // One pipeline access with a memory that acks after 'delay' wait cycles.
    task automatic do_access(input string name, input logic rd, input logic wr,
                             input logic [1:0] sz, input logic sg, input logic [31:0] a,
                             input logic [31:0] wd, input int delay, input logic [31:0] rdata);
        logic        acc;
        logic        bad;
        logic [31:0] exp_rd;
        int          stalls;
        acc    = rd | wr;
        bad    = model_bad(sz, a);
        exp_rd = wr ? 32'h0 : model_load(sz, sg, a, rdata);
        @(negedge clk);
        memreadM = rd; memwriteM = wr; sizeM = sz; signedM = sg;
        aluoutM = a; writedataM = wd; mem_ack = 1'b0;
        #1;
        checks++;
        if (misalignM !== (acc & bad)) begin
            errors++;
            $display("FAIL %s misalign: got %b exp %b", name, misalignM, acc & bad);
        end
        stalls = (stallM === 1'b1) ? 1 : 0;
        if (!acc || bad) begin
            @(negedge clk);
            checks++;
            if (mem_req !== 1'b0 || stallM !== 1'b0 || readdataM !== 32'h0) begin
                errors++;
                $display("FAIL %s no-access: req=%b stall=%b rdata=%h exp 0/0/0",
                         name, mem_req, stallM, readdataM);
            end
            memreadM = 1'b0; memwriteM = 1'b0;
            return;
        end
        for (int k = 0; k <= delay; k++) begin
            @(negedge clk);
            checks++;
            if (mem_req !== 1'b1) begin
                errors++;
                $display("FAIL %s req[%0d]: got %b exp 1", name, k, mem_req);
            end
            if (stallM === 1'b1) stalls++;
            if (k == delay) begin
                checks++;
                if (mem_we !== wr || mem_addr !== (a & 32'hFFFF_FFFC) ||
                    mem_be !== model_be(sz, a) || mem_wdata !== model_wdata(sz, wd)) begin
                    errors++;
                    $display("FAIL %s fields: we=%b addr=%h be=%b wd=%h exp %b %h %b %h",
                             name, mem_we, mem_addr, mem_be, mem_wdata,
                             wr, a & 32'hFFFF_FFFC, model_be(sz, a), model_wdata(sz, wd));
                end
            end
            mem_ack   = (k == delay);
            mem_rdata = (k == delay) ? rdata : $urandom;
        end
        @(negedge clk);
        // Stray acks outside REQ must have no effect.
        mem_ack   = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
        checks++;
        if (stallM !== 1'b0 || mem_req !== 1'b0 || buserrM !== 1'b0) begin
            errors++;
            $display("FAIL %s done-ctl: stall=%b req=%b berr=%b exp 0/0/0",
                     name, stallM, mem_req, buserrM);
        end
        checks++;
        if (readdataM !== exp_rd) begin
            errors++;
            $display("FAIL %s readdata: got %h exp %h", name, readdataM, exp_rd);
        end
        checks++;
        if (stalls != delay + 2) begin
            errors++;
            $display("FAIL %s stall_cycles: got %0d exp %0d", name, stalls, delay + 2);
        end
        memreadM = 1'b0; memwriteM = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        memreadM = 1'b0; memwriteM = 1'b0; sizeM = 2'd0; signedM = 1'b0;
        aluoutM = 32'h0; writedataM = 32'h0; mem_ack = 1'b0; mem_rdata = 32'h0;
        repeat (3) @(negedge clk);
        checks++;
        if (readdataM !== 32'h0 || stallM !== 1'b0 || buserrM !== 1'b0 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctl: rdata=%h stall=%b berr=%b req=%b exp 0",
                     readdataM, stallM, buserrM, mem_req);
        end
        checks++;
        if (mem_we !== 1'b0 || mem_addr !== 32'h0 || mem_be !== 4'h0 || mem_wdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_bus: we=%b addr=%h be=%b wd=%h exp 0",
                     mem_we, mem_addr, mem_be, mem_wdata);
        end
        rst = 1'b1;
    endtask

    task automatic test_directed();
        do_access("lw_0x100", 1'b1, 1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 0, 32'hDEAD_BEEF);
        do_access("lb_0x103", 1'b1, 1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 1, 32'h80FF_0000);
        do_access("lbu_0x103", 1'b1, 1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 0, 32'h80FF_0000);
        do_access("sh_0x102", 1'b0, 1'b1, 2'd1, 1'b0, 32'h102, 32'h1234_ABCD, 2, 32'h5555_5555);
        do_access("lw_0x101", 1'b1, 1'b0, 2'd2, 1'b0, 32'h101, 32'h0, 0, 32'h0);
        do_access("size11", 1'b0, 1'b1, 2'd3, 1'b0, 32'h200, 32'hFFFF_FFFF, 0, 32'h0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            logic        rd;
            logic        wr;
            logic [1:0]  sz;
            logic [31:0] a;
            rd = 1'($urandom_range(0, 1));
            wr = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            a  = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'd1) a = a & 32'hFFFF_FFFE;
                if (sz == 2'd2) a = a & 32'hFFFF_FFFC;
            end
            do_access("random", rd, wr, sz, 1'($urandom_range(0, 1)), a, $urandom,
                      $urandom_range(0, 3), $urandom);
        end
    endtask

    task automatic test_timeout();
        int req_cnt;
        int berr_cnt;
        req_cnt  = 0;
        berr_cnt = 0;
        do_access("pre_to", 1'b1, 1'b0, 2'd2, 1'b0, 32'h300, 32'h0, 0, 32'hCAFE_F00D);
        @(negedge clk);
        memreadM = 1'b1; memwriteM = 1'b0; sizeM = 2'd2; aluoutM = 32'h304; mem_ack = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (mem_req === 1'b1) req_cnt++;
            if (buserrM === 1'b1) begin
                berr_cnt++;
                checks++;
                if (readdataM !== 32'h0 || stallM !== 1'b0) begin
                    errors++;
                    $display("FAIL timeout_done: rdata=%h stall=%b exp 0/0", readdataM, stallM);
                end
                memreadM = 1'b0;
            end
        end
        checks++;
        if (req_cnt != 4) begin
            errors++;
            $display("FAIL timeout_req_cycles: got %0d exp 4", req_cnt);
        end
        checks++;
        if (berr_cnt != 1) begin
            errors++;
            $display("FAIL timeout_buserr_pulses: got %0d exp 1", berr_cnt);
        end
        memreadM = 1'b0;
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        memreadM = 1'b1; memwriteM = 1'b0; sizeM = 2'd2; aluoutM = 32'h400; mem_ack = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b1 || stallM !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_pre: req=%b stall=%b exp 1/1", mem_req, stallM);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b0 || stallM !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_drop: req=%b stall=%b exp 0/0", mem_req, stallM);
        end
        @(negedge clk);
        memreadM = 1'b0;
        rst = 1'b1;
        do_access("lw_after_rst", 1'b1, 1'b0, 2'd2, 1'b0, 32'h404, 32'h0, 1, 32'h1357_9BDF);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_directed();
        test_random();
        test_timeout();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
        $fatal(1);
    end

endmodule
`default_nettype wire
